// File: rtl/poly_coef_mem_pp_if.sv
// Producer/consumer bus of the ping-pong coefficient memory.
// master: the datapath driving writes, reads, swaps and clears.
// slave : the memory itself.
interface poly_coef_mem_pp_if #(
  parameter int COEF_WIDTH = 13,
  parameter int ADDR_BITS  = 11
);
  logic                  wr_en;
  logic [ADDR_BITS-1:0]  wr_addr;
  logic [COEF_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_BITS-1:0]  rd_addr;
  logic [COEF_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  swap_req;
  logic                  swap_ack;
  logic                  clr_req;
  logic                  clr_busy;
  logic                  wr_bank;
  logic                  oob_err;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, swap_req, clr_req,
    input  rd_data, rd_valid, swap_ack, clr_busy, wr_bank, oob_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, swap_req, clr_req,
    output rd_data, rd_valid, swap_ack, clr_busy, wr_bank, oob_err
  );
endinterface

// File: rtl/poly_coef_mem_pp.sv
// Ping-pong coefficient memory for SNTRUP757 polynomial datapaths.
// Two banks: writes go to bank wr_bank, reads come from bank ~wr_bank.
// A swap exchanges the banks; a clear sequencer zeroes the write bank.
// Optional macro POLY_MEM_RANGE_CHECK_EN rejects writes with data >= Q.
module poly_coef_mem_pp #(
  parameter int COEF_WIDTH = 13,
  parameter int ADDR_BITS  = 11,
  parameter int DEPTH      = 757,
  parameter int Q          = 4591
) (
  input  logic clk,
  input  logic rst_n,
  poly_coef_mem_pp_if.slave bus
);
  localparam int WORDS = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(DEPTH - 1);

  // Reject configurations that cannot hold DEPTH entries or have no usable modulus.
  if (DEPTH > WORDS || DEPTH < 1 || Q < 1) begin : g_bad_cfg
    $error("poly_coef_mem_pp: bad DEPTH/ADDR_BITS/Q configuration");
  end

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  bank_q, bank_d;
  logic                  ack_q, ack_d;
  logic [COEF_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  oob_q;

  // Storage is not reset; locations DEPTH..WORDS-1 are never written or read out.
  logic [COEF_WIDTH-1:0] mem_q [2][WORDS];

  logic                  wr_addr_ok, wr_data_ok, wr_ok, rd_ok, wr_err;
  logic                  mem_we;
  logic [ADDR_BITS-1:0]  mem_waddr;
  logic [COEF_WIDTH-1:0] mem_wdata;

  assign wr_addr_ok = 32'(bus.wr_addr) < DEPTH;
  assign rd_ok      = 32'(bus.rd_addr) < DEPTH;
`ifdef POLY_MEM_RANGE_CHECK_EN
  assign wr_data_ok = 32'(bus.wr_data) < Q;
`else
  assign wr_data_ok = 1'b1;
`endif
  assign wr_ok  = wr_addr_ok & wr_data_ok;
  // Producer writes are silently dropped during a clear, so no error then.
  assign wr_err = (state_q == IDLE) & bus.wr_en & ~wr_ok;

  // Write port mux: the clear sequencer owns the write bank while it runs.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else begin
      mem_we    = bus.wr_en & wr_ok;
    end
  end

  // Bank storage write.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[bank_q][mem_waddr] <= mem_wdata;
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      bank_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      bank_q  <= bank_d;
      ack_q   <= ack_d;
    end
  end

  // Next state: clear wins over swap; a swap seen during a clear is deferred
  // to the edge that returns the sequencer to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    bank_d  = bank_q;
    ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          pend_d  = bus.swap_req;
        end else if (bus.swap_req) begin
          bank_d = ~bank_q;
          ack_d  = 1'b1;
        end
      end
      CLEAR: begin
        if (bus.swap_req) pend_d = 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (pend_q || bus.swap_req) begin
            bank_d = ~bank_q;
            ack_d  = 1'b1;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + ADDR_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered read from the opposite bank plus the one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      oob_q      <= wr_err | (bus.rd_en & ~rd_ok);
      if (bus.rd_en) rd_data_q <= rd_ok ? mem_q[~bank_q][bus.rd_addr] : '0;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.swap_ack = ack_q;
  assign bus.clr_busy = (state_q == CLEAR);
  assign bus.wr_bank  = bank_q;
  assign bus.oob_err  = oob_q;
endmodule

// File: doc/poly_coef_mem_pp.md
Name: poly_coef_mem_pp

Overview:
- Ping-pong coefficient memory for SNTRUP757 polynomial datapaths; parametrised successor of the single-bank distributed coefficient RAM.
- Two banks: the producer writes one bank while the consumer reads the other; a swap handshake exchanges them.
- Built-in clear sequencer zeroes the write bank in hardware.
- Registered (1-cycle) read, address range checking, optional coefficient range check.

Parameters:
- COEF_WIDTH, 13, coefficient bit width.
- ADDR_BITS, 11, address width; per-bank storage is 2**ADDR_BITS words.
- DEPTH, 757, number of valid entries per bank; must satisfy DEPTH <= 2**ADDR_BITS.
- Q, 4591, modulus; used only by the optional feature.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- wr_en  in  1  write strobe to the write bank.
- wr_addr  in  ADDR_BITS  write address.
- wr_data  in  COEF_WIDTH  write data.
- rd_en  in  1  read strobe from the read bank.
- rd_addr  in  ADDR_BITS  read address.
- rd_data  out  COEF_WIDTH  registered read data.
- rd_valid  out  1  pulses 1 cycle with rd_data.
- swap_req  in  1  request bank exchange (level sampled per cycle).
- swap_ack  out  1  1-cycle pulse when the swap takes effect.
- clr_req  in  1  start zeroing the write bank.
- clr_busy  out  1  high while the clear sequencer runs.
- wr_bank  out  1  current write bank index; read bank = ~wr_bank.
- oob_err  out  1  1-cycle pulse: access rejected (bad address or, with the option, bad data).

Behaviour:
- Reset (async, rst_n=0): wr_bank=0, rd_data=0, rd_valid=0, swap_ack=0, clr_busy=0, oob_err=0, FSM=IDLE, swap_pend=0, clear counter=0. Memory contents are not reset.
- Write: the memory write happens on the edge where wr_en=1, into bank wr_bank.
  - Write is dropped if wr_addr >= DEPTH; oob_err pulses the next cycle.
  - Write is dropped while clr_busy=1 (no error flagged).
- Read: rd_en=1 in cycle N reads bank ~wr_bank at the value wr_bank has in cycle N. rd_data/rd_valid appear in cycle N+1.
  - If rd_addr >= DEPTH: rd_data=0, rd_valid=1, oob_err pulses in N+1.
  - rd_data holds its last value when rd_en=0.
  - Reads proceed during a clear.
- Read and write go to different banks, so they never collide. Simultaneous rd_en/wr_en is always legal.
- FSM states: IDLE, CLEAR.
- IDLE, clr_req=1: go to CLEAR; clr_busy=1 from the next cycle; counter=0.
  - Any swap_req in that same cycle sets swap_pend; clear has priority.
- IDLE, swap_req=1 (no clr_req): wr_bank toggles on that edge; swap_ack=1 for the following cycle.
  - A held swap_req toggles every cycle; the producer must pulse it.
- CLEAR: writes 0 to wr_bank[counter] each cycle, counter 0..DEPTH-1. clr_busy is high for exactly DEPTH cycles.
  - clr_req during CLEAR is ignored.
  - swap_req during CLEAR sets swap_pend.
  - After the counter=DEPTH-1 write, return to IDLE.
  - If swap_pend=1: wr_bank toggles on the IDLE entry edge, swap_ack pulses, swap_pend clears.
- Reset asserted mid-clear aborts immediately. Partially cleared contents remain; no other side effects.
- Locations with addresses DEPTH..2**ADDR_BITS-1 are never written and never read out.

Optional Feature:
- Macro: POLY_MEM_RANGE_CHECK_EN.
- Defined: a write with wr_data >= Q is dropped and oob_err pulses the next cycle, same as an address error.
- Undefined: no data check; any COEF_WIDTH value is stored. Address checking is unchanged.

Test Plan:
- Reset mid-clear: rst_n low for 2 cycles at clear counter=300 -> clr_busy=0, wr_bank=0, rd_valid=0, oob_err=0 immediately. Next clr_req restarts at counter 0 (757 busy cycles).
- Fill/swap/read: write addr k data (3k mod 4591) for k=0..756 into bank 0, pulse swap_req -> swap_ack next cycle, wr_bank=1. rd_en addr 5 -> rd_data=15, rd_valid=1 one cycle later. Addr 756 -> 2268.
- Clear: with wr_bank=1, pulse clr_req -> clr_busy high exactly 757 cycles. Reads of bank 0 still return 3k during the clear. A wr_en during the clear is dropped. Swap, then read addr 100 -> 0.
- Swap during clear: swap_req at clear cycle 10 -> no toggle until clear ends. wr_bank toggles and swap_ack pulses on the cycle clr_busy falls.
- Out of range: write addr 800 data 7 -> oob_err pulse, no memory change. Read addr 800 -> rd_data=0, rd_valid=1, oob_err pulse.
- Option: with POLY_MEM_RANGE_CHECK_EN, write 4591 to addr 3 -> dropped, oob_err pulse, old value retained. 4590 is accepted. Without the macro, 4591 is stored and read back.
